bmd_cpl_responder: RTL and testbench
====================================

# bmd_cpl_responder

Endpoint-side completer for the BMD PCIe example design. It accepts single-DW memory requests that the root port issues against BAR0 and applies writes to a small control/status register file. Reads are answered with PCIe-rule completions. It sits between the CPM completer-request (CQ) unpacker and the completion (CC) packer, in the endpoint user-clock domain.

## Interface
Parameters:
- NUM_REGS, 16: number of 32-bit registers decoded from BAR0 offset 0; legal range 4..64.
- UR_CNT_W, 8: width of the unsupported-request counter.

Ports (name, direction, width, meaning):
- user_clk  in  1  block clock.
- user_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request descriptor valid.
- req_ready  out  1  block can accept a request.
- req_is_write  in  1  1 = MemWr, 0 = MemRd.
- req_addr  in  12  byte address within BAR0; bits [1:0] are ignored.
- req_dw_count  in  11  payload length in DW.
- req_be  in  4  first-DW byte enables.
- req_data  in  32  write payload.
- req_tag  in  8  request tag.
- req_id  in  16  requester ID.
- req_tc  in  3  traffic class.
- cpl_valid  out  1  completion descriptor valid.
- cpl_ready  in  1  downstream packer accepts the completion.
- cpl_data  out  32  read data.
- cpl_status  out  3  completion status: 3'b000 SC, 3'b001 UR.
- cpl_tag  out  8  echoed from req_tag.
- cpl_req_id  out  16  echoed from req_id.
- cpl_tc  out  3  echoed from req_tc.
- cpl_lower_addr  out  7  lower address field of the completion.
- cpl_byte_count  out  12  byte count field of the completion.
- ctrl_reg  out  32  register 0.
- status_in  in  32  value returned when register 1 is read.
- irq_set  in  32  per-bit sticky set pulses into register 2.
- ur_count  out  UR_CNT_W  saturating count of unsupported requests.

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture all req_* fields and go to EXEC.
  - EXEC: one cycle. Decode, perform the register write, or sample the read data. Writes go to IDLE; reads go to CPL.
  - CPL: cpl_valid=1 with all cpl_* fields held stable. When cpl_ready=1, go to IDLE.
- Decode: idx = req_addr[11:2]. A request is unsupported (UR) if req_dw_count != 1 or idx >= NUM_REGS.
- Register map:
  - reg0: RW, drives ctrl_reg.
  - reg1: RO, returns status_in; writes are ignored.
  - reg2: RW1C.
  - reg3..NUM_REGS-1: RW scratch.
- Write merge: each byte is updated only where req_be is set. req_be=0 writes nothing.
- reg2 update each cycle: reg2 <= (reg2 & ~clear_mask) | irq_set. If a set and a clear hit the same bit in the same cycle, the set wins.
- UR write: dropped and ur_count increments. UR read: completion with cpl_status=UR, cpl_data=0, and ur_count increments. ur_count saturates at all-ones.
- cpl_lower_addr = {req_addr[6:2], lb}, where lb is the index of the lowest set bit of req_be (0 if req_be=0).
- cpl_byte_count (single-DW rule):
  - req_be=0 gives 1.
  - Otherwise it is msb-lsb+1 over the set bits of req_be. Examples: 4'b1111 gives 4, 4'b0110 gives 2, 4'b1001 gives 4.
  - UR completions use the same rule.
- Reset values:
  - req_ready=1 after reset is released.
  - cpl_valid=0, all cpl_* fields 0.
  - ctrl_reg=0, all registers 0, ur_count=0, FSM in IDLE.
- Asserting reset mid-operation aborts the request. No completion is emitted.

## Timing
- Request handshake in cycle N. EXEC occurs in N+1. cpl_valid rises in N+2 (read latency is 2 cycles).
- Read data is sampled in EXEC. For reg1, cpl_data equals status_in as it was in cycle N+1.
- A write is visible on ctrl_reg and in register reads from N+2 onward. req_ready is low in N+1 and high again in N+2, so the next request can be accepted in N+2.
- req_ready is low throughout EXEC and CPL. Only one request is outstanding at a time.
- cpl_ready low: the block stalls indefinitely with all fields stable. cpl_valid never drops without a handshake.
- cpl_ready high when CPL is entered: cpl_valid lasts one cycle and IDLE is entered in the next cycle.

## Structure
- Package bmd_cpl_pkg holds:
  - completion status constants (CPL_SC, CPL_UR);
  - register index constants (REG_CTRL=0, REG_STATUS=1, REG_IRQ=2);
  - the FSM state enum;
  - the function computing byte count and lower-address bits from a 4-bit byte enable.
- One sub-module, bmd_reg_file, contains the register array, byte-enable merge, RW1C/sticky logic and read mux. The FSM, decode and counter stay in the top.

## Test plan
- Write 0xDEADBEEF to offset 0x000 with be=4'b1111 -> ctrl_reg=0xDEADBEEF at N+2, and no completion is produced.
- Read offset 0x004 while status_in=0x12345678 and cpl_ready is held low for 5 cycles -> cpl_valid is stable for 5 cycles with data 0x12345678, SC, byte_count 4, lower_addr 0x04.
- Read with be=4'b0110 at offset 0x00C -> byte_count 2, lower_addr 0x0D, and the tag, requester ID and TC are echoed.
- Set reg2=0x3 via irq_set, then write 0x1 to offset 0x008 in the same cycle that irq_set=0x1 -> reg2 reads back 0x3 (set wins). A later clear of 0x1 alone -> reads 0x2.
- Read offset 0x100 with NUM_REGS=16, then a 2-DW write -> one UR completion with data 0, the write is dropped, and ur_count=2. After 300 UR requests ur_count=255.
- Assert user_reset while in CPL -> cpl_valid goes to 0 immediately, all registers read back 0 after release, and req_ready=1.

Source files
------------

// File: rtl/bmd_cpl_pkg.sv
// Shared types and helpers for the BMD completer: status codes, register
// indices, FSM state, captured request layout and byte-enable decode.
package bmd_cpl_pkg;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_IRQ    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CPL  = 2'd2
  } state_e;

  // Request fields held for the duration of one transaction. Only the DW
  // address is kept; the byte offset comes from the byte enables.
  typedef struct packed {
    logic        is_write;
    logic [9:0]  addr_dw;
    logic [10:0] dw_count;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] id;
    logic [2:0]  tc;
  } req_t;

  typedef struct packed {
    logic [11:0] byte_count;
    logic [1:0]  lb;
  } be_info_t;

  // Single-DW completion fields from the first-DW byte enables: span of set
  // bytes (1 when none are set) and the index of the lowest set byte.
  function automatic be_info_t be_info(input logic [3:0] be);
    be_info_t r;
    logic [1:0] lsb;
    logic [1:0] msb;
    lsb = 2'd0;
    msb = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (be[i]) lsb = 2'(i);
    for (int i = 0; i < 4; i++)
      if (be[i]) msb = 2'(i);
    if (be == 4'b0000) begin
      r.byte_count = 12'd1;
      r.lb         = 2'd0;
    end else begin
      r.byte_count = 12'(msb - lsb) + 12'd1;
      r.lb         = lsb;
    end
    return r;
  endfunction

endpackage

// File: rtl/bmd_reg_file.sv
// BAR0 control/status register file: byte-masked writes, read-only status
// passthrough, sticky interrupt register with write-1-to-clear.
module bmd_reg_file
  import bmd_cpl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic [31:0]      status_in,
  input  logic [31:0]      irq_set,
  output logic [31:0]      rd_data,
  output logic [31:0]      ctrl_reg
);

  logic [NUM_REGS-1:0][31:0] regs;
  logic [31:0] be_mask;
  logic [31:0] merged;
  logic [31:0] clr_mask;

  // Byte-lane mask, merged write value and RW1C clear mask for this cycle.
  always_comb begin
    be_mask  = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    merged   = (regs[idx] & ~be_mask) | (wr_data & be_mask);
    clr_mask = '0;
    if (wr_en && idx == IDX_W'(REG_IRQ))
      clr_mask = wr_data & be_mask;
  end

  // Register update: irq bits are set every cycle (set beats clear); the
  // status slot is never stored since reads return status_in directly.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == REG_IRQ)
          regs[r] <= (regs[r] & ~clr_mask) | irq_set;
        else if (r != REG_STATUS && wr_en && idx == IDX_W'(r))
          regs[r] <= merged;
      end
    end
  end

  // Read mux; the caller guarantees idx < NUM_REGS.
  always_comb begin
    rd_data = regs[idx];
    if (idx == IDX_W'(REG_STATUS))
      rd_data = status_in;
  end

  assign ctrl_reg = regs[REG_CTRL];

endmodule

// File: rtl/bmd_cpl_responder.sv
// BAR0 single-DW completer: accepts one CQ request at a time, applies writes
// to the register file and returns a completion for every read.
module bmd_cpl_responder
  import bmd_cpl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int UR_CNT_W = 8
) (
  input  logic                user_clk,
  input  logic                user_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_write,
  input  logic [11:0]         req_addr,
  input  logic [10:0]         req_dw_count,
  input  logic [3:0]          req_be,
  input  logic [31:0]         req_data,
  input  logic [7:0]          req_tag,
  input  logic [15:0]         req_id,
  input  logic [2:0]          req_tc,
  output logic                cpl_valid,
  input  logic                cpl_ready,
  output logic [31:0]         cpl_data,
  output logic [2:0]          cpl_status,
  output logic [7:0]          cpl_tag,
  output logic [15:0]         cpl_req_id,
  output logic [2:0]          cpl_tc,
  output logic [6:0]          cpl_lower_addr,
  output logic [11:0]         cpl_byte_count,
  output logic [31:0]         ctrl_reg,
  input  logic [31:0]         status_in,
  input  logic [31:0]         irq_set,
  output logic [UR_CNT_W-1:0] ur_count
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e      state;
  req_t        rq;
  logic        is_ur;
  logic        wr_en;
  logic [31:0] rd_data;
  be_info_t    bi;
  logic        addr_lsb_unused;

  // Byte offset bits carry no information for DW-aligned accesses.
  assign addr_lsb_unused = ^req_addr[1:0];

  assign is_ur = (rq.dw_count != 11'd1) || (rq.addr_dw >= 10'(NUM_REGS));
  assign wr_en = (state == ST_EXEC) && rq.is_write && !is_ur;
  assign bi    = be_info(rq.be);

  bmd_reg_file #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regs (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .wr_en      (wr_en),
    .idx        (rq.addr_dw[IDX_W-1:0]),
    .wr_be      (rq.be),
    .wr_data    (rq.data),
    .status_in  (status_in),
    .irq_set    (irq_set),
    .rd_data    (rd_data),
    .ctrl_reg   (ctrl_reg)
  );

  // Request FSM with registered handshake/completion outputs and UR counter.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state          <= ST_IDLE;
      rq             <= '0;
      req_ready      <= 1'b1;
      cpl_valid      <= 1'b0;
      cpl_data       <= '0;
      cpl_status     <= '0;
      cpl_tag        <= '0;
      cpl_req_id     <= '0;
      cpl_tc         <= '0;
      cpl_lower_addr <= '0;
      cpl_byte_count <= '0;
      ur_count       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            rq.is_write <= req_is_write;
            rq.addr_dw  <= req_addr[11:2];
            rq.dw_count <= req_dw_count;
            rq.be       <= req_be;
            rq.data     <= req_data;
            rq.tag      <= req_tag;
            rq.id       <= req_id;
            rq.tc       <= req_tc;
            req_ready   <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_ur && ur_count != '1)
            ur_count <= ur_count + UR_CNT_W'(1);
          if (rq.is_write) begin
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cpl_valid      <= 1'b1;
            cpl_data       <= is_ur ? 32'h0 : rd_data;
            cpl_status     <= is_ur ? CPL_UR : CPL_SC;
            cpl_tag        <= rq.tag;
            cpl_req_id     <= rq.id;
            cpl_tc         <= rq.tc;
            cpl_lower_addr <= {rq.addr_dw[4:0], bi.lb};
            cpl_byte_count <= bi.byte_count;
            state          <= ST_CPL;
          end
        end
        ST_CPL: begin
          if (cpl_ready) begin
            cpl_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmd_cpl_responder.sv
// Directed bench for bmd_cpl_responder: register writes, stalled and
// byte-enable reads, RW1C priority, UR handling/saturation, mid-CPL reset.
module tb_bmd_cpl_responder;

  logic        user_clk = 1'b0;
  logic        user_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic [11:0] req_addr;
  logic [10:0] req_dw_count;
  logic [3:0]  req_be;
  logic [31:0] req_data;
  logic [7:0]  req_tag;
  logic [15:0] req_id;
  logic [2:0]  req_tc;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [31:0] cpl_data;
  logic [2:0]  cpl_status;
  logic [7:0]  cpl_tag;
  logic [15:0] cpl_req_id;
  logic [2:0]  cpl_tc;
  logic [6:0]  cpl_lower_addr;
  logic [11:0] cpl_byte_count;
  logic [31:0] ctrl_reg;
  logic [31:0] status_in;
  logic [31:0] irq_set;
  logic [7:0]  ur_count;

  int checks   = 0;
  int failures = 0;

  bmd_cpl_responder #(.NUM_REGS(16), .UR_CNT_W(8)) dut (
    .user_clk       (user_clk),
    .user_reset     (user_reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_write   (req_is_write),
    .req_addr       (req_addr),
    .req_dw_count   (req_dw_count),
    .req_be         (req_be),
    .req_data       (req_data),
    .req_tag        (req_tag),
    .req_id         (req_id),
    .req_tc         (req_tc),
    .cpl_valid      (cpl_valid),
    .cpl_ready      (cpl_ready),
    .cpl_data       (cpl_data),
    .cpl_status     (cpl_status),
    .cpl_tag        (cpl_tag),
    .cpl_req_id     (cpl_req_id),
    .cpl_tc         (cpl_tc),
    .cpl_lower_addr (cpl_lower_addr),
    .cpl_byte_count (cpl_byte_count),
    .ctrl_reg       (ctrl_reg),
    .status_in      (status_in),
    .irq_set        (irq_set),
    .ur_count       (ur_count)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the following negedge (EXEC).
  task automatic send(input logic w, input logic [11:0] a, input logic [10:0] dwc,
                      input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 8) begin @(negedge user_clk); n++; end
    req_valid    = 1'b1;
    req_is_write = w;
    req_addr     = a;
    req_dw_count = dwc;
    req_be       = be;
    req_data     = d;
    @(negedge user_clk);
    req_valid    = 1'b0;
  endtask

  task automatic wait_cpl();
    int n = 0;
    @(negedge user_clk);
    while (!cpl_valid && n < 8) begin @(negedge user_clk); n++; end
    chk("cpl_seen", {31'b0, cpl_valid}, 32'd1);
  endtask

  // Read with cpl_ready high; completion fields are checked by the caller
  // via the r_* copies taken while cpl_valid is high.
  logic [31:0] r_data;
  logic [2:0]  r_status;
  logic [6:0]  r_la;
  logic [11:0] r_bc;

  task automatic do_read(input logic [11:0] a, input logic [3:0] be);
    cpl_ready = 1'b1;
    send(1'b0, a, 11'd1, be, 32'h0);
    wait_cpl();
    r_data   = cpl_data;
    r_status = cpl_status;
    r_la     = cpl_lower_addr;
    r_bc     = cpl_byte_count;
    @(negedge user_clk);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    send(1'b1, a, 11'd1, be, d);
    @(negedge user_clk);
  endtask

  initial begin
    user_reset = 1'b1;
    req_valid = 0; req_is_write = 0; req_addr = 0; req_dw_count = 11'd1;
    req_be = 0; req_data = 0; req_tag = 8'h11; req_id = 16'h0100; req_tc = 3'd0;
    cpl_ready = 1'b1; status_in = 32'h0; irq_set = 32'h0;
    repeat (3) @(negedge user_clk);
    chk("rst_cpl_valid", {31'b0, cpl_valid}, 32'd0);
    chk("rst_cpl_data", cpl_data, 32'h0);
    chk("rst_ctrl", ctrl_reg, 32'h0);
    chk("rst_ur", {24'b0, ur_count}, 32'd0);
    user_reset = 1'b0;
    @(negedge user_clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Full-DW write to reg0: no completion, visible at N+2.
    send(1'b1, 12'h000, 11'd1, 4'hF, 32'hDEADBEEF);
    chk("wr_exec_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge user_clk);
    chk("wr_ctrl", ctrl_reg, 32'hDEADBEEF);
    chk("wr_ready_back", {31'b0, req_ready}, 32'd1);
    chk("wr_no_cpl", {31'b0, cpl_valid}, 32'd0);

    // Status read stalled 5 cycles; status_in changes after EXEC.
    cpl_ready = 1'b0;
    status_in = 32'h12345678;
    req_tag = 8'h22;
    send(1'b0, 12'h004, 11'd1, 4'hF, 32'h0);
    @(negedge user_clk);
    status_in = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, cpl_valid}, 32'd1);
      chk("stall_data", cpl_data, 32'h12345678);
      chk("stall_ready_low", {31'b0, req_ready}, 32'd0);
      @(negedge user_clk);
    end
    chk("stall_status", {29'b0, cpl_status}, 32'd0);
    chk("stall_bc", {20'b0, cpl_byte_count}, 32'd4);
    chk("stall_la", {25'b0, cpl_lower_addr}, 32'h04);
    chk("stall_tag", {24'b0, cpl_tag}, 32'h22);
    cpl_ready = 1'b1;
    @(negedge user_clk);
    chk("stall_release_valid", {31'b0, cpl_valid}, 32'd0);
    chk("stall_release_ready", {31'b0, req_ready}, 32'd1);

    // Scratch reg3: full write, then byte-masked merge.
    do_write(12'h00C, 4'hF, 32'hA5A51234);
    do_write(12'h00C, 4'b0011, 32'hFFFFFFFF);
    req_tag = 8'h5A; req_id = 16'hBEEF; req_tc = 3'd5;
    cpl_ready = 1'b1;
    send(1'b0, 12'h00C, 11'd1, 4'b0110, 32'h0);
    @(negedge user_clk);
    chk("be0110_valid", {31'b0, cpl_valid}, 32'd1);
    chk("be0110_data", cpl_data, 32'hA5A5FFFF);
    chk("be0110_bc", {20'b0, cpl_byte_count}, 32'd2);
    chk("be0110_la", {25'b0, cpl_lower_addr}, 32'h0D);
    chk("be0110_tag", {24'b0, cpl_tag}, 32'h5A);
    chk("be0110_id", {16'b0, cpl_req_id}, 32'hBEEF);
    chk("be0110_tc", {29'b0, cpl_tc}, 32'd5);
    @(negedge user_clk);
    chk("be0110_one_cycle", {31'b0, cpl_valid}, 32'd0);

    do_read(12'h00C, 4'b1001);
    chk("be1001_bc", {20'b0, r_bc}, 32'd4);
    chk("be1001_la", {25'b0, r_la}, 32'h0C);

    // be=0: write does nothing, read reports byte count 1.
    do_write(12'h000, 4'b0000, 32'h00000000);
    chk("be0_wr_ctrl", ctrl_reg, 32'hDEADBEEF);
    do_read(12'h000, 4'b0000);
    chk("be0_rd_data", r_data, 32'hDEADBEEF);
    chk("be0_rd_bc", {20'b0, r_bc}, 32'd1);
    chk("be0_rd_la", {25'b0, r_la}, 32'h00);

    // Writes to the read-only status register are ignored.
    status_in = 32'h0000ABCD;
    do_write(12'h004, 4'hF, 32'hFFFFFFFF);
    do_read(12'h004, 4'hF);
    chk("ro_status", r_data, 32'h0000ABCD);

    // Sticky irq: set 0x3, then clear bit 0 while it is being set again.
    irq_set = 32'h3;
    @(negedge user_clk);
    irq_set = 32'h0;
    send(1'b1, 12'h008, 11'd1, 4'hF, 32'h1);
    irq_set = 32'h1;
    @(negedge user_clk);
    irq_set = 32'h0;
    do_read(12'h008, 4'hF);
    chk("irq_set_wins", r_data, 32'h3);
    do_write(12'h008, 4'hF, 32'h1);
    do_read(12'h008, 4'hF);
    chk("irq_clear", r_data, 32'h2);

    // Unsupported requests.
    do_read(12'h100, 4'hF);
    chk("ur_rd_status", {29'b0, r_status}, 32'd1);
    chk("ur_rd_data", r_data, 32'h0);
    chk("ur_rd_bc", {20'b0, r_bc}, 32'd4);
    chk("ur_rd_la", {25'b0, r_la}, 32'h00);
    chk("ur_cnt1", {24'b0, ur_count}, 32'd1);
    send(1'b1, 12'h000, 11'd2, 4'hF, 32'h11111111);
    @(negedge user_clk);
    chk("ur_wr_no_cpl", {31'b0, cpl_valid}, 32'd0);
    chk("ur_wr_dropped", ctrl_reg, 32'hDEADBEEF);
    chk("ur_cnt2", {24'b0, ur_count}, 32'd2);
    for (int i = 0; i < 298; i++) begin
      send(1'b1, 12'h100, 11'd1, 4'hF, 32'h0);
      @(negedge user_clk);
    end
    chk("ur_saturate", {24'b0, ur_count}, 32'd255);

    // Reset while a completion is pending.
    cpl_ready = 1'b0;
    send(1'b0, 12'h000, 11'd1, 4'hF, 32'h0);
    @(negedge user_clk);
    chk("pre_rst_valid", {31'b0, cpl_valid}, 32'd1);
    user_reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, cpl_valid}, 32'd0);
    @(negedge user_clk);
    user_reset = 1'b0;
    @(negedge user_clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_ctrl", ctrl_reg, 32'h0);
    chk("post_rst_ur", {24'b0, ur_count}, 32'd0);
    chk("post_rst_cpl_valid", {31'b0, cpl_valid}, 32'd0);
    do_read(12'h008, 4'hF);
    chk("post_rst_irq", r_data, 32'h0);
    do_read(12'h00C, 4'hF);
    chk("post_rst_scratch", r_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
